// File: rtl/tc_pkg.sv
// tc_pkg: framing constants and receiver state type shared by both ends of the TC link.
package tc_pkg;

  localparam int unsigned TC_WORD_W    = 32;
  localparam int unsigned TC_NUM_WORDS = 10;
  localparam int unsigned TC_TIMEOUT   = 1024;

  typedef enum logic {
    IDLE,
    RECV
  } tc_state_e;

endpackage

// File: rtl/tc_sync_edge.sv
// tc_sync_edge: brings tcclk_in and sin into the sysclk domain through equal-depth
// synchronizer chains and flags each rising edge of the synchronized tcclk.
module tc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tcclk_in,
  input  logic sin,
  output logic clk_rise,
  output logic sin_s
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] sin_sync;
  logic                   clk_prev;

  // Shift both inputs through their synchronizer chains; keep the last clock level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      sin_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], tcclk_in};
      sin_sync <= {sin_sync[SYNC_STAGES-2:0], sin};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronized clock; data taken from the same-depth chain.
  always_comb begin
    clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    sin_s    = sin_sync[SYNC_STAGES-1];
  end

endmodule

// File: rtl/tc_rx.sv
// tc_rx: telecommand serial receiver. Oversamples tcclk_in/sin on sysclk, rebuilds
// MSB-first words, strobes each word with its index, and flags frame completion
// and inter-edge timeouts.
// Build option TC_RX_PARITY_EN: every word is followed by an odd-parity bit and a
// parity_err strobe accompanies word_valid.
module tc_rx
  import tc_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = TC_NUM_WORDS,
  parameter int unsigned WORD_W      = TC_WORD_W,
  parameter int unsigned TIMEOUT     = TC_TIMEOUT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic                         tcclk_in,
  input  logic                         sin,
  output logic [WORD_W-1:0]            word_data,
  output logic [$clog2(NUM_WORDS)-1:0] word_idx,
  output logic                         word_valid,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic                         busy
`ifdef TC_RX_PARITY_EN
  ,
  output logic                         parity_err
`endif
);

`ifdef TC_RX_PARITY_EN
  localparam int unsigned BPW = WORD_W + 1;
`else
  localparam int unsigned BPW = WORD_W;
`endif
  localparam int unsigned BC_W  = $clog2(BPW + 1);
  localparam int unsigned WC_W  = $clog2(NUM_WORDS + 1);
  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(BPW - 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);

  logic              clk_rise;
  logic              sin_s;
  tc_state_e         state, state_n;
  logic [BPW-2:0]    sreg, sreg_n;
  logic [BPW-1:0]    full;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_n;
  logic [WC_W-1:0]   word_cnt, word_cnt_n;
  logic [TO_W-1:0]   to_cnt;
  logic [WORD_W-1:0] data_n;
  logic [IDX_W-1:0]  idx_n;
  logic              valid_n, done_n, err_n;
`ifdef TC_RX_PARITY_EN
  logic              perr_n;
`endif

  tc_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (sysclk),
    .rst_n    (reset),
    .tcclk_in (tcclk_in),
    .sin      (sin),
    .clk_rise (clk_rise),
    .sin_s    (sin_s)
  );

  assign busy = (state == RECV);

  // State register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Cycles since the last detected edge, saturating; cleared by every edge.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                to_cnt <= '0;
    else if (clk_rise)         to_cnt <= '0;
    else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
  end

  // Next state, shift/counter updates and strobe generation.
  // The word is delivered on the detect cycle of its last bit so the strobe is
  // registered one cycle later; the FSM stays in RECV through the frame_done
  // cycle so busy drops the cycle after it.
  always_comb begin
    state_n    = state;
    sreg_n     = sreg;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    data_n     = word_data;
    idx_n      = word_idx;
    valid_n    = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
`ifdef TC_RX_PARITY_EN
    perr_n     = 1'b0;
`endif
    full       = {sreg, sin_s};
    unique case (state)
      IDLE: begin
        if (clk_rise) begin
          state_n    = RECV;
          sreg_n     = '0;
          sreg_n[0]  = sin_s;
          bit_cnt_n  = BC_W'(1);
          word_cnt_n = '0;
        end
      end
      RECV: begin
        if (frame_done) begin
          state_n    = IDLE;
          word_cnt_n = '0;
        end else if (clk_rise) begin
          sreg_n = full[BPW-2:0];
          if (bit_cnt == LAST_BIT) begin
`ifdef TC_RX_PARITY_EN
            data_n = full[BPW-1:1];
            perr_n = ~(^full);
`else
            data_n = full;
`endif
            idx_n      = IDX_W'(word_cnt);
            valid_n    = 1'b1;
            done_n     = (word_cnt == LAST_WORD);
            bit_cnt_n  = '0;
            word_cnt_n = word_cnt + WC_W'(1);
          end else begin
            bit_cnt_n = bit_cnt + BC_W'(1);
          end
        end else if (to_cnt == TO_LAST) begin
          err_n      = 1'b1;
          state_n    = IDLE;
          sreg_n     = '0;
          bit_cnt_n  = '0;
          word_cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      word_data  <= '0;
      word_idx   <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
`ifdef TC_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      sreg       <= sreg_n;
      bit_cnt    <= bit_cnt_n;
      word_cnt   <= word_cnt_n;
      word_data  <= data_n;
      word_idx   <= idx_n;
      word_valid <= valid_n;
      frame_done <= done_n;
      frame_err  <= err_n;
`ifdef TC_RX_PARITY_EN
      parity_err <= perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_tc_rx.sv
// tb_tc_rx: scoreboard bench for tc_rx. Stimulus predicts strobe events from the
// bit stream (rise times, word assembly, gap-vs-timeout rule) into a queue; a
// negedge monitor pops and compares whenever the DUT strobes.
module tb_tc_rx;

  localparam int unsigned NW  = 10;
  localparam int unsigned WW  = 32;
  localparam int unsigned TO  = 1024;
  localparam int unsigned SS  = 2;
  localparam int unsigned LAT = SS + 1;
`ifdef TC_RX_PARITY_EN
  localparam int unsigned BPW = WW + 1;
`else
  localparam int unsigned BPW = WW;
`endif

  logic                   sysclk = 1'b0;
  logic                   reset;
  logic                   tcclk_in;
  logic                   sin;
  logic [WW-1:0]          word_data;
  logic [$clog2(NW)-1:0]  word_idx;
  logic                   word_valid, frame_done, frame_err, busy;
`ifdef TC_RX_PARITY_EN
  logic                   parity_err;
`endif

  tc_rx #(
    .NUM_WORDS   (NW),
    .WORD_W      (WW),
    .TIMEOUT     (TO),
    .SYNC_STAGES (SS)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .tcclk_in   (tcclk_in),
    .sin        (sin),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .word_valid (word_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef TC_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 sysclk = ~sysclk;

  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    int unsigned   cyc;
    logic [WW-1:0] data;
    int unsigned   idx;
    bit            done;
    bit            perr;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  bit  busy_chk = 1'b0;

  // Reference model state.
  bit            cur_bits[$];
  bit            in_frame = 1'b0;
  int unsigned   words_done = 0;
  int unsigned   last_rise = 0;
  logic [WW-1:0] last_word = '0;
  int unsigned   last_idx = 0;

  // Stimulus configuration.
  logic [WW-1:0] words [NW];
  bit            flip  [NW];
  bit            rnd_phase = 1'b0;
  int unsigned   gap_bit = 32'hFFFF_FFFF;
  int unsigned   gap_lo  = 4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.cyc    = last_rise + TO + LAT;
    e.data   = last_word;
    e.idx    = last_idx;
    e.done   = 1'b0;
    e.perr   = 1'b0;
    q.push_back(e);
    in_frame = 1'b0;
  endtask

  // Bit whose tcclk rise is driven at cycle c.
  task automatic model_bit(input bit b, input int unsigned c);
    ev_t           e;
    logic [WW-1:0] w;
    bit            x;
    if (in_frame && (c - last_rise > TO)) push_err();
    if (!in_frame) begin
      in_frame   = 1'b1;
      words_done = 0;
      cur_bits.delete();
    end
    last_rise = c;
    cur_bits.push_back(b);
    if (cur_bits.size() == BPW) begin
      w = '0;
      for (int i = 0; i < int'(WW); i++) w = {w[WW-2:0], cur_bits[i]};
      x = 1'b0;
      foreach (cur_bits[i]) x ^= cur_bits[i];
      e.is_err = 1'b0;
      e.cyc    = c + LAT;
      e.data   = w;
      e.idx    = words_done;
      e.done   = (words_done == NW - 1);
`ifdef TC_RX_PARITY_EN
      e.perr   = (x == 1'b0);
`else
      e.perr   = 1'b0;
`endif
      q.push_back(e);
      last_word = w;
      last_idx  = words_done;
      words_done++;
      cur_bits.delete();
      if (words_done == NW) in_frame = 1'b0;
    end
  endtask

  // Called at a negedge with tcclk_in low.
  task automatic send_bit(input bit b, input int unsigned lo, input int unsigned hi);
    model_bit(b, cyc + lo);
    sin = b;
    repeat (lo) @(negedge sysclk);
    tcclk_in = 1'b1;
    repeat (hi) @(negedge sysclk);
    tcclk_in = 1'b0;
  endtask

  task automatic send_frame(input int unsigned nbits);
    for (int unsigned k = 0; k < nbits; k++) begin
      int unsigned wi, pos, lo, hi;
      bit          b;
      wi  = k / BPW;
      pos = k % BPW;
      if (pos < WW) b = words[wi][WW-1-pos];
      else          b = ~(^words[wi]) ^ flip[wi];
      lo = rnd_phase ? $urandom_range(5, 2) : 4;
      hi = rnd_phase ? $urandom_range(5, 2) : 4;
      if (k == gap_bit) lo = gap_lo;
      send_bit(b, lo, hi);
    end
  endtask

  task automatic idle_gap(input int unsigned n);
    if (in_frame) push_err();
    repeat (n) @(negedge sysclk);
  endtask

  task automatic load_directed();
    words[0] = 32'hAAAAAAAA; words[1] = 32'hCCCCCCCC; words[2] = 32'hE38E38E3;
    words[3] = 32'hF0F0F0F0; words[4] = 32'hF83E0F83; words[5] = 32'hFC0FC0FC;
    words[6] = 32'h77777777; words[7] = 32'h88888888; words[8] = 32'h99999999;
    words[9] = 32'hAAAAAAAA;
    for (int i = 0; i < int'(NW); i++) flip[i] = 1'b0;
    flip[9] = 1'b1;
  endtask

  task automatic load_random();
    for (int i = 0; i < int'(NW); i++) begin
      words[i] = $urandom;
      flip[i]  = ($urandom_range(3, 0) == 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word_data"},  word_data,  0);
    chk({tag, "_word_idx"},   word_idx,   0);
    chk({tag, "_word_valid"}, word_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_err"},  frame_err,  0);
    chk({tag, "_busy"},       busy,       0);
  endtask

  task automatic model_reset();
    q.delete();
    cur_bits.delete();
    in_frame   = 1'b0;
    words_done = 0;
    last_word  = '0;
    last_idx   = 0;
    busy_chk   = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge sysclk) begin : mon
    ev_t e;
    if (reset === 1'b1) begin
      if (busy_chk) begin
        chk("busy_after_done", busy, 0);
        busy_chk = 1'b0;
      end
      if (word_valid || frame_err || frame_done) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {word_valid, frame_done, frame_err}, 0);
        end else begin
          e = q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("word_valid", word_valid, !e.is_err);
          chk("frame_err", frame_err, e.is_err);
          chk("frame_done", frame_done, e.done);
          chk("word_data", word_data, e.data);
          chk("word_idx", word_idx, e.idx);
`ifdef TC_RX_PARITY_EN
          chk("parity_err", parity_err, e.perr);
`endif
          if (e.done) begin
            chk("busy_at_done", busy, 1);
            busy_chk = 1'b1;
          end
        end
      end
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    reset    = 1'b1;
    tcclk_in = 1'b0;
    sin      = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);
    chk("idle_busy", busy, 0);

    // Directed frame at tcclk = sysclk/8.
    load_directed();
    send_frame(NW * BPW);
    idle_gap(20);

    // Clock stops after 45 bits: word 0 delivered, then timeout.
    send_frame(45);
    idle_gap(TO + 20);
    send_frame(NW * BPW);
    idle_gap(20);

    // Asynchronous reset in bit 17 of word 3.
    load_random();
    send_frame(3 * BPW + 17);
    chk("busy_mid_frame", busy, 1);
    #3 reset = 1'b0;
    model_reset();
    #1 chk_reset_outputs("midrst");
    repeat (4) @(negedge sysclk);
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    chk_reset_outputs("postrst");
    load_directed();
    send_frame(NW * BPW);
    idle_gap(20);

    // Rise gap of exactly TIMEOUT cycles survives; one more cycle aborts.
    load_random();
    gap_bit = 50;
    gap_lo  = TO - 4;
    send_frame(NW * BPW);
    idle_gap(20);
    gap_lo  = TO - 3;
    send_frame(NW * BPW);
    idle_gap(TO + 20);
    gap_bit = 32'hFFFF_FFFF;

    // Random frames with random tcclk phases.
    rnd_phase = 1'b1;
    for (int f = 0; f < 3; f++) begin
      load_random();
      send_frame(NW * BPW);
      idle_gap($urandom_range(30, 1));
    end

    idle_gap(30);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
